peripheral_mpi_noc_arbiter: RTL and testbench

- Packet-granular round-robin arbiter. Shares one NoC output link between N packet sources, such as the per-channel noc_out streams of the MPI buffer.
- Once a source is granted, the grant is held until that source's last flit is accepted, so packets never interleave.
- The output is registered through a 2-entry skid buffer. It sits between the MPI buffer/BIU and the router local port.

---
 rtl/peripheral_mpi_pkg.sv | 35 +++
 rtl/peripheral_mpi_noc_skid.sv | 91 +++++++++
 rtl/peripheral_mpi_noc_arbiter.sv | 135 +++++++++++++
 tb/tb_peripheral_mpi_noc_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_mpi_pkg.sv
// Shared types and helpers for the MPI NoC output path.
// Holds the arbiter state encoding and the round-robin selector.
package peripheral_mpi_pkg;

  localparam int DEF_NOC_FLIT_WIDTH = 32;
  localparam int RR_MAX = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } arb_state_e;

  // First set bit of req scanning ptr, ptr+1, ... wrapping at n.
  function automatic logic [RR_MAX-1:0] rr_select(
    input logic [RR_MAX-1:0] req,
    input logic [3:0]        ptr,
    input logic [4:0]        n
  );
    logic [RR_MAX-1:0] sel;
    logic [4:0]        idx;
    logic              found;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < RR_MAX; k++) begin
      idx = {1'b0, ptr} + 5'(k);
      if (idx >= n) idx = idx - n;
      if (5'(k) < n && !found && req[idx[3:0]]) begin
        sel[idx[3:0]] = 1'b1;
        found         = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/peripheral_mpi_noc_skid.sv
// Two-entry flit/last skid buffer with valid/ready on both sides.
// Upstream ready is registered: it reflects occupancy after the last edge.
module peripheral_mpi_noc_skid #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] d0_q, d0_d;
  logic [W-1:0] d1_q, d1_d;
  logic         l0_q, l0_d;
  logic         l1_q, l1_d;
  logic         rdy_q, rdy_d;
  logic         push;
  logic         pop;

  assign in_ready  = rdy_q;
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = d0_q;
  assign out_last  = l0_q;
  assign push      = in_valid & rdy_q;
  assign pop       = out_valid & out_ready;

  // Entry 0 is always the head; a pop shifts entry 1 forward.
  always_comb begin
    cnt_d = cnt_q;
    d0_d  = d0_q;
    l0_d  = l0_q;
    d1_d  = d1_q;
    l1_d  = l1_q;
    unique case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          d0_d = in_data;
          l0_d = in_last;
        end else begin
          d1_d = in_data;
          l1_d = in_last;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        d0_d  = d1_q;
        l0_d  = l1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          d0_d = in_data;
          l0_d = in_last;
        end else begin
          d0_d = d1_q;
          l0_d = l1_q;
          d1_d = in_data;
          l1_d = in_last;
        end
      end
      default: ;
    endcase
    rdy_d = (cnt_d < 2'd2);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      d0_q  <= '0;
      d1_q  <= '0;
      l0_q  <= 1'b0;
      l1_q  <= 1'b0;
      rdy_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      d0_q  <= d0_d;
      d1_q  <= d1_d;
      l0_q  <= l0_d;
      l1_q  <= l1_d;
      rdy_q <= rdy_d;
    end
  end

endmodule

// File: rtl/peripheral_mpi_noc_arbiter.sv
// Packet-granular round-robin arbiter onto one NoC link.
// A grant is held until the owner's last flit is accepted.
module peripheral_mpi_noc_arbiter
  import peripheral_mpi_pkg::*;
#(
  parameter int NOC_FLIT_WIDTH = DEF_NOC_FLIT_WIDTH,
  parameter int N              = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N*NOC_FLIT_WIDTH-1:0] in_flit,
  input  logic [N-1:0]                in_last,
  input  logic [N-1:0]                in_valid,
  output logic [N-1:0]                in_ready,
  output logic [NOC_FLIT_WIDTH-1:0]   out_flit,
  output logic                        out_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N-1:0]                grant,
  output logic                        busy
);

  localparam int W  = NOC_FLIT_WIDTH;
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  arb_state_e    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;

  logic [RR_MAX-1:0] req_ext;
  logic [RR_MAX-1:0] sel_ext;
  logic [3:0]        ptr_ext;
  logic              sel_unused;
  logic [PW-1:0]     owner_idx;
  logic [PW-1:0]     ptr_next;

  logic          skid_in_ready;
  logic          skid_valid;
  logic          skid_last;
  logic [W-1:0]  skid_flit;
  logic          xfer_last;

  assign grant = grant_q;

  always_comb begin
    req_ext              = '0;
    req_ext[N-1:0]       = in_valid;
    ptr_ext              = '0;
    ptr_ext[PW-1:0]      = rr_ptr_q;
    sel_ext              = rr_select(req_ext, ptr_ext, 5'(N));
  end

  assign sel_unused = ^sel_ext;

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) owner_idx = PW'(i);
    end
  end

  // Explicit wrap so non-power-of-2 N rotates correctly.
  assign ptr_next = (owner_idx == PW'(N - 1)) ? '0
                  : owner_idx + PW'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (|in_valid) begin
          grant_d = sel_ext[N-1:0];
          state_d = GRANTED;
        end
      end
      GRANTED: begin
        if (xfer_last) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = ptr_next;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready   = '0;
    busy       = 1'b0;
    skid_valid = 1'b0;
    skid_last  = 1'b0;
    skid_flit  = '0;
    for (int i = 0; i < N; i++) begin
      skid_flit = skid_flit
                | (in_flit[i*W +: W] & {W{grant_q[i]}});
      skid_last = skid_last | (in_last[i] & grant_q[i]);
    end
    if (state_q == GRANTED) begin
      busy       = 1'b1;
      in_ready   = grant_q & {N{skid_in_ready}};
      skid_valid = |(in_valid & grant_q);
    end
  end

  assign xfer_last = |(in_valid & in_ready & in_last);

  peripheral_mpi_noc_skid #(
    .W(W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_data  (skid_flit),
    .in_last  (skid_last),
    .in_valid (skid_valid),
    .in_ready (skid_in_ready),
    .out_data (out_flit),
    .out_last (out_last),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

endmodule

// File: tb/tb_peripheral_mpi_noc_arbiter.sv
// Bench for peripheral_mpi_noc_arbiter: N=2 against a packet model,
// plus an N=4 instance for the pointer wrap.
module tb_peripheral_mpi_noc_arbiter;

  localparam int W = 32;

  typedef struct packed {
    logic [31:0] flit;
    logic        last;
    logic        gap;
  } ent_t;

  typedef struct packed {
    logic [31:0] f;
    logic        l;
  } mq_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [2*W-1:0] in_flit0;
  logic [1:0]     in_last0, in_valid0, in_ready0, grant0;
  logic [W-1:0]   out_flit0;
  logic           out_last0, out_valid0, out_ready0, busy0;

  logic [4*W-1:0] in_flit1;
  logic [3:0]     in_last1, in_valid1, in_ready1, grant1;
  logic [W-1:0]   out_flit1;
  logic           out_last1, out_valid1, out_ready1, busy1;

  peripheral_mpi_noc_arbiter #(.NOC_FLIT_WIDTH(W), .N(2)) u0 (
    .clk(clk), .rst(rst),
    .in_flit(in_flit0), .in_last(in_last0),
    .in_valid(in_valid0), .in_ready(in_ready0),
    .out_flit(out_flit0), .out_last(out_last0),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .grant(grant0), .busy(busy0)
  );

  peripheral_mpi_noc_arbiter #(.NOC_FLIT_WIDTH(W), .N(4)) u1 (
    .clk(clk), .rst(rst),
    .in_flit(in_flit1), .in_last(in_last1),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .out_flit(out_flit1), .out_last(out_last1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .grant(grant1), .busy(busy1)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  ent_t sq0[$];
  ent_t sq1[$];
  logic gap0, gap1;
  logic [1:0] took0;
  logic [3:0] take1;
  int acc0;
  logic gap_mon;
  int gapchk;

  logic [31:0] log_f[$];
  logic        log_l[$];
  int          log_c[$];
  logic [31:0] exp_f[$];
  logic        exp_l[$];
  logic [31:0] log1[$];
  logic [3:0]  gseq[$];
  logic [3:0]  g1_prev;

  // packet-level model of the N=2 instance
  int  m_owner = -1;
  int  m_rr    = 0;
  bit  m_init  = 0;
  mq_t mq[$];

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic sample();
    logic [1:0] eg;
    logic [1:0] eir;
    logic       xfer;
    cyc++;
    if (m_init) begin
      eg = '0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      eir = (m_owner >= 0 && mq.size() < 2) ? eg : 2'b00;
      chk("m_grant", grant0, eg);
      chk("m_busy", busy0, m_owner >= 0);
      chk("m_in_ready", in_ready0, eir);
      chk("m_out_valid", out_valid0, mq.size() > 0);
      if (mq.size() > 0) begin
        chk("m_out_flit", out_flit0, mq[0].f);
        chk("m_out_last", out_last0, mq[0].l);
      end
    end
    if (out_valid0 === 1'b1 && out_ready0) begin
      log_f.push_back(out_flit0);
      log_l.push_back(out_last0);
      log_c.push_back(cyc);
    end
    took0 = in_valid0 & in_ready0;
    if (took0[0]) acc0++;
    if (gap_mon && gap1) begin
      gapchk++;
      chk("t4_grant", grant0, 2'b10);
      chk("t4_other_ready", in_ready0[0], 1'b0);
      chk("t4_other_valid", in_valid0[0], 1'b1);
    end
    take1 = in_valid1 & in_ready1;
    if (out_valid1 === 1'b1 && out_ready1)
      log1.push_back(out_flit1);
    if (grant1 !== g1_prev && grant1 !== 4'b0)
      gseq.push_back(grant1);
    g1_prev = grant1;
    if (!rst) begin
      m_owner = -1;
      m_rr    = 0;
      mq.delete();
      m_init  = 1;
    end else begin
      xfer = (m_owner >= 0) && in_valid0[m_owner]
           && (mq.size() < 2);
      if (mq.size() > 0 && out_ready0) mq.delete(0);
      if (xfer)
        mq.push_back('{in_flit0[m_owner*W +: W],
                       in_last0[m_owner]});
      if (m_owner < 0) begin
        for (int k = 0; k < 2; k++) begin
          int i;
          i = (m_rr + k) % 2;
          if (m_owner < 0 && in_valid0[i]) m_owner = i;
        end
      end else if (xfer && in_last0[m_owner]) begin
        m_rr    = (m_owner + 1) % 2;
        m_owner = -1;
      end
    end
  endtask

  task automatic drive();
    if ((took0[0] || gap0) && sq0.size() > 0) sq0.delete(0);
    gap0 = 1'b0;
    in_valid0[0] = 1'b0;
    if (sq0.size() > 0) begin
      if (sq0[0].gap) gap0 = 1'b1;
      else begin
        in_valid0[0]   = 1'b1;
        in_flit0[W-1:0] = sq0[0].flit;
        in_last0[0]    = sq0[0].last;
      end
    end
    if ((took0[1] || gap1) && sq1.size() > 0) sq1.delete(0);
    gap1 = 1'b0;
    in_valid0[1] = 1'b0;
    if (sq1.size() > 0) begin
      if (sq1[0].gap) gap1 = 1'b1;
      else begin
        in_valid0[1]       = 1'b1;
        in_flit0[2*W-1:W] = sq1[0].flit;
        in_last0[1]        = sq1[0].last;
      end
    end
    in_valid1 = in_valid1 & ~take1;
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic wait_log(int n, string name);
    int k;
    k = 0;
    while (log_f.size() < n && k < 200) begin
      step();
      k++;
    end
    chk(name, log_f.size() >= n, 1'b1);
  endtask

  task automatic settle();
    repeat (3) step();
  endtask

  task automatic clear_log();
    log_f.delete();
    log_l.delete();
    log_c.delete();
  endtask

  task automatic chk_log(string name);
    chk({name, "_count"}, log_f.size(), exp_f.size());
    for (int i = 0; i < exp_f.size(); i++) begin
      if (i < log_f.size()) begin
        chk({name, "_flit"}, log_f[i], exp_f[i]);
        chk({name, "_last"}, log_l[i], exp_l[i]);
      end
    end
  endtask

  function automatic ent_t fl(logic [31:0] f, logic l);
    return '{f, l, 1'b0};
  endfunction

  function automatic ent_t gp();
    return '{32'h0, 1'b0, 1'b1};
  endfunction

  initial begin
    int k;
    int d2[7];
    rst = 1'b0;
    in_flit0 = '0; in_last0 = '0; in_valid0 = '0;
    out_ready0 = 1'b1;
    in_flit1 = {32'h103, 32'h102, 32'h101, 32'h100};
    in_last1 = 4'hf; in_valid1 = '0; out_ready1 = 1'b1;
    gap0 = 0; gap1 = 0; took0 = '0; take1 = '0;
    acc0 = 0; gap_mon = 0; gapchk = 0; g1_prev = '0;

    repeat (3) step();
    chk("rst_grant", grant0, 2'b00);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_out_valid", out_valid0, 1'b0);
    chk("rst_out_flit", out_flit0, 32'h0);
    chk("rst_out_last", out_last0, 1'b0);
    chk("rst_in_ready", in_ready0, 2'b00);
    rst = 1'b1;
    step(); step();

    // single source, 3-flit packet, latency pinned
    sq0.push_back(fl(32'hA0, 0));
    sq0.push_back(fl(32'hA1, 0));
    sq0.push_back(fl(32'hA2, 1));
    step();
    chk("t1_grant_pre", grant0, 2'b00);
    step();
    chk("t1_grant", grant0, 2'b01);
    chk("t1_busy", busy0, 1'b1);
    step();
    chk("t1_first_valid", out_valid0, 1'b1);
    chk("t1_first_flit", out_flit0, 32'hA0);
    wait_log(3, "t1_timeout");
    exp_f = '{32'hA0, 32'hA1, 32'hA2};
    exp_l = '{1'b0, 1'b0, 1'b1};
    chk_log("t1");
    if (log_c.size() >= 3)
      chk("t1_stream", log_c[2] - log_c[0], 2);
    settle();

    // pointer now 1: simultaneous singles go src1 then src0
    clear_log();
    sq0.push_back(fl(32'hB0, 1));
    sq1.push_back(fl(32'hC0, 1));
    wait_log(2, "t1b_timeout");
    exp_f = '{32'hC0, 32'hB0};
    exp_l = '{1'b1, 1'b1};
    chk_log("t1b");
    settle();
    clear_log();
    sq1.push_back(fl(32'hC1, 1));
    wait_log(1, "t1c_timeout");
    settle();

    // contention, 2-flit packets from both sources
    clear_log();
    sq0.push_back(fl(32'hD00, 0)); sq0.push_back(fl(32'hD01, 1));
    sq0.push_back(fl(32'hD02, 0)); sq0.push_back(fl(32'hD03, 1));
    sq1.push_back(fl(32'hE10, 0)); sq1.push_back(fl(32'hE11, 1));
    sq1.push_back(fl(32'hE12, 0)); sq1.push_back(fl(32'hE13, 1));
    wait_log(8, "t2_timeout");
    exp_f = '{32'hD00, 32'hD01, 32'hE10, 32'hE11,
              32'hD02, 32'hD03, 32'hE12, 32'hE13};
    exp_l = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    chk_log("t2");
    d2 = '{1, 2, 1, 2, 1, 2, 1};
    if (log_c.size() >= 8)
      for (int i = 0; i < 7; i++)
        chk("t2_spacing", log_c[i+1] - log_c[i], d2[i]);
    settle();

    // backpressure mid-packet
    clear_log();
    acc0 = 0;
    sq0.push_back(fl(32'hF0, 0)); sq0.push_back(fl(32'hF1, 0));
    sq0.push_back(fl(32'hF2, 0)); sq0.push_back(fl(32'hF3, 1));
    wait_log(1, "t3_timeout_a");
    out_ready0 = 1'b0;
    repeat (5) step();
    chk("t3_in_ready", in_ready0, 2'b00);
    chk("t3_held", acc0 - log_f.size(), 2);
    chk("t3_out_valid", out_valid0, 1'b1);
    chk("t3_head", out_flit0, 32'hF1);
    out_ready0 = 1'b1;
    wait_log(4, "t3_timeout_b");
    settle();
    exp_f = '{32'hF0, 32'hF1, 32'hF2, 32'hF3};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
    chk_log("t3");

    // owner gap while the other source waits
    clear_log();
    gapchk = 0;
    gap_mon = 1'b1;
    sq1.push_back(fl(32'hB60, 0));
    sq1.push_back(gp()); sq1.push_back(gp()); sq1.push_back(gp());
    sq1.push_back(fl(32'hB61, 0)); sq1.push_back(fl(32'hB62, 1));
    sq0.push_back(fl(32'hC70, 1));
    wait_log(4, "t4_timeout");
    gap_mon = 1'b0;
    chk("t4_gap_cycles", gapchk, 3);
    exp_f = '{32'hB60, 32'hB61, 32'hB62, 32'hC70};
    exp_l = '{1'b0, 1'b0, 1'b1, 1'b1};
    chk_log("t4");
    settle();

    // reset with one flit in the skid
    clear_log();
    out_ready0 = 1'b0;
    acc0 = 0;
    sq0.push_back(fl(32'h90, 0)); sq0.push_back(fl(32'h91, 0));
    sq0.push_back(fl(32'h92, 0)); sq0.push_back(fl(32'h93, 1));
    k = 0;
    while (acc0 < 1 && k < 50) begin
      step();
      k++;
    end
    chk("t5_accept", acc0, 1);
    chk("t5_pre_valid", out_valid0, 1'b1);
    rst = 1'b0;
    step();
    chk("t5_out_valid", out_valid0, 1'b0);
    chk("t5_grant", grant0, 2'b00);
    chk("t5_busy", busy0, 1'b0);
    chk("t5_in_ready", in_ready0, 2'b00);
    sq0.delete(); sq1.delete();
    in_valid0 = '0; in_last0 = '0;
    rst = 1'b1;
    out_ready0 = 1'b1;
    step(); step();
    chk("t5_discard", log_f.size(), 0);
    sq1.push_back(fl(32'h81, 1));
    sq0.push_back(fl(32'h80, 1));
    wait_log(2, "t5_timeout");
    exp_f = '{32'h80, 32'h81};
    exp_l = '{1'b1, 1'b1};
    chk_log("t5");
    settle();

    // N=4: drive pointer to 3, then 3 and 0 contend
    log1.delete();
    gseq.delete();
    in_valid1 = 4'b0100;
    k = 0;
    while (log1.size() < 1 && k < 50) begin
      step();
      k++;
    end
    settle();
    in_valid1 = 4'b1001;
    k = 0;
    while (log1.size() < 3 && k < 50) begin
      step();
      k++;
    end
    settle();
    chk("t6_count", log1.size(), 3);
    chk("t6_gcount", gseq.size(), 3);
    if (log1.size() >= 3) begin
      chk("t6_out0", log1[0], 32'h102);
      chk("t6_out1", log1[1], 32'h103);
      chk("t6_out2", log1[2], 32'h100);
    end
    if (gseq.size() >= 3) begin
      chk("t6_g0", gseq[0], 4'b0100);
      chk("t6_g1", gseq[1], 4'b1000);
      chk("t6_g2", gseq[2], 4'b0001);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
